// File: rtl/sort8_drain.sv
// Ping-pong drain buffer: captures one 8-word sorted vector per handshake and streams it as 8 serial beats.
// Define SORT8_DRAIN_DESC_EN to emit elements in descending index order (y7 first).
module sort8_drain #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] y0,
    input  logic [W-1:0] y1,
    input  logic [W-1:0] y2,
    input  logic [W-1:0] y3,
    input  logic [W-1:0] y4,
    input  logic [W-1:0] y5,
    input  logic [W-1:0] y6,
    input  logic [W-1:0] y7,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [2:0]   out_idx,
    output logic         out_last
);

    // state | meaning
    // EMPTY | no slot holds a vector
    // ONE   | one slot full (draining), capture slot free
    // TWO   | both slots full, capture blocked
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   slot_q [2][8];
    logic [W-1:0]   slot_d [2][8];
    logic [1:0]     full_q, full_d;
    logic           wr_sel_q, wr_sel_d;
    logic           rd_sel_q, rd_sel_d;
    logic [2:0]     cnt_q, cnt_d;

    logic [W-1:0]   in_vec [8];
    logic           capture;
    logic           xfer;
    logic           last_xfer;
    logic [2:0]     k;

    always_comb begin
        in_vec[0] = y0;
        in_vec[1] = y1;
        in_vec[2] = y2;
        in_vec[3] = y3;
        in_vec[4] = y4;
        in_vec[5] = y5;
        in_vec[6] = y6;
        in_vec[7] = y7;
    end

`ifdef SORT8_DRAIN_DESC_EN
    assign k = 3'd7 - cnt_q;
`else
    assign k = cnt_q;
`endif

    // in_ready comes from registered state only, so out_ready never reaches it combinationally
    assign in_ready  = (state_q != TWO);
    assign capture   = in_valid && in_ready;
    assign out_valid = full_q[rd_sel_q];
    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && (cnt_q == 3'd7);

    always_comb begin
        out_data = '0;
        out_idx  = 3'd0;
        out_last = 1'b0;
        if (out_valid) begin
            out_data = slot_q[rd_sel_q][k];
            out_idx  = k;
            out_last = (cnt_q == 3'd7);
        end
    end

    always_comb begin
        slot_d   = slot_q;
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        cnt_d    = cnt_q;
        state_d  = state_q;

        // The capture slot and the draining slot never coincide while the drain slot is full
        if (capture) begin
            for (int i = 0; i < 8; i++) begin
                slot_d[wr_sel_q][i] = in_vec[i];
            end
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
        end

        if (xfer) begin
            cnt_d = cnt_q + 3'd1;
            if (last_xfer) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = ~rd_sel_q;
            end
        end

        case (state_q)
            EMPTY: if (capture) state_d = ONE;
            ONE: begin
                if (capture && !last_xfer)      state_d = TWO;
                else if (!capture && last_xfer) state_d = EMPTY;
            end
            TWO:     if (last_xfer) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= EMPTY;
            full_q   <= 2'b00;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            cnt_q    <= 3'd0;
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < 8; i++) begin
                    slot_q[s][i] <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            cnt_q    <= cnt_d;
            slot_q   <= slot_d;
        end
    end

endmodule
